// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: the scanout read owns every p_tick=0 slot, and draw-engine writes queue in a small FIFO.
// Define VRAM_VBLANK_WR_EN to restrict queued writes to vertical blank (y >= 480).
module vram_arbiter #(
    parameter int FB_W       = 160,
    parameter int FB_H       = 120,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        p_tick,
    input  logic        video_on,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [14:0] wr_addr,
    input  logic [7:0]  wr_data,
    output logic        mem_en,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  pixel,
    output logic [2:0]  fifo_level,
    output logic        oob_err
);
    localparam int          PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [31:0] FB_SIZE = 32'(FB_W * FB_H);
    localparam logic [2:0]  DEPTH_L = 3'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_DISP, ST_CAP, ST_WR} slot_t;

    slot_t            state_reg, state_next;
    logic [14:0]      q_addr [FIFO_DEPTH];
    logic [7:0]       q_data [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg;
    logic [2:0]       level_reg;
    logic             ready_en_reg;
    logic             oob_reg;
    logic [7:0]       pixel_reg;

    logic        disp_slot, wr_slot, wr_window, head_oob, push, pop;
    logic [14:0] scan_addr, head_addr;

`ifdef VRAM_VBLANK_WR_EN
    assign wr_window = (y >= 10'd480);
`else
    assign wr_window = 1'b1;
`endif

    // Every framebuffer pixel is shown as a 4x4 block on screen.
    assign scan_addr = 15'(y >> 2) * 15'(FB_W) + 15'(x >> 2);
    assign head_addr = q_addr[rd_ptr_reg];
    assign head_oob  = (32'(head_addr) >= FB_SIZE);

    // The read slot is unconditional; a write may only take a cycle the read does not want.
    assign disp_slot = reset_n && !p_tick && video_on;
    assign wr_slot   = reset_n && !disp_slot && (level_reg != 3'd0) && wr_window;

    assign wr_ready = ready_en_reg && (level_reg < DEPTH_L);
    assign push     = wr_valid && wr_ready;
    assign pop      = wr_slot;

    always_comb begin
        state_next = ST_IDLE;
        if (disp_slot)
            state_next = ST_DISP;
        else if (wr_slot)
            state_next = ST_WR;
        else if (state_reg == ST_DISP)
            state_next = ST_CAP;
    end

    // Out-of-range heads are still popped, but the strobe is suppressed.
    assign mem_en    = disp_slot || (wr_slot && !head_oob);
    assign mem_we    = wr_slot && !head_oob;
    assign mem_addr  = disp_slot ? scan_addr : head_addr;
    assign mem_wdata = q_data[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr_reg] <= wr_addr;
            q_data[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            level_reg    <= 3'd0;
            ready_en_reg <= 1'b0;
            oob_reg      <= 1'b0;
            pixel_reg    <= 8'd0;
        end else begin
            state_reg    <= state_next;
            ready_en_reg <= 1'b1;
            // Read data returns one cycle after the read slot, even if that cycle carries a write.
            if (state_reg == ST_DISP)
                pixel_reg <= mem_rdata;
            else if (p_tick)
                pixel_reg <= 8'd0;
            if (pop && head_oob)
                oob_reg <= 1'b1;
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   level_reg <= level_reg + 3'd1;
                2'b01:   level_reg <= level_reg - 3'd1;
                default: level_reg <= level_reg;
            endcase
        end
    end

    assign pixel      = pixel_reg;
    assign fifo_level = level_reg;
    assign oob_err    = oob_reg;
endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized bench for vram_arbiter: a queue/array reference model predicts every VRAM strobe and register each cycle.
module tb_vram_arbiter;
    localparam int FB_W  = 160;
    localparam int FB_H  = 120;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n, p_tick, video_on, wr_valid, wr_ready;
    logic [9:0]  x, y;
    logic [14:0] wr_addr, mem_addr;
    logic [7:0]  wr_data, mem_wdata, mem_rdata, pixel;
    logic        mem_en, mem_we, oob_err;
    logic [2:0]  fifo_level;

    always #5 clk = ~clk;

    vram_arbiter #(.FB_W(FB_W), .FB_H(FB_H), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .p_tick(p_tick), .video_on(video_on),
        .x(x), .y(y), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .pixel(pixel), .fifo_level(fifo_level), .oob_err(oob_err)
    );

    // Synchronous single-port VRAM seen by the DUT.
    logic [7:0] vram [0:32767];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) vram[mem_addr] <= mem_wdata;
            else        mem_rdata <= vram[mem_addr];
        end
    end

    // Reference model state.
    typedef struct { logic [14:0] a; logic [7:0] d; } wr_t;
    wr_t        m_q[$];
    logic [7:0] ref_vram [0:32767];
    logic [7:0] m_pixel, m_rd;
    logic       m_prev_disp, m_oob, m_ready_en;
    logic       pt_hold;
    int         n_vec, n_err;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cycle();
        logic        disp, can_wr, e_en, e_we, e_rdy;
        logic [14:0] e_addr;
        logic [7:0]  e_data;
        int          raddr;
        wr_t         h;
        @(negedge clk);
        if (!reset_n) begin
            m_q.delete();
            m_pixel = 8'd0; m_oob = 1'b0; m_prev_disp = 1'b0; m_ready_en = 1'b0;
        end
        disp   = reset_n && !p_tick && video_on;
        can_wr = reset_n && !disp && (m_q.size() > 0);
`ifdef VRAM_VBLANK_WR_EN
        if (y < 10'd480) can_wr = 1'b0;
`endif
        e_rdy = m_ready_en && (m_q.size() < DEPTH);
        e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_data = '0;
        if (disp) begin
            raddr  = (int'(y) / 4) * FB_W + int'(x) / 4;
            e_en   = 1'b1;
            e_addr = 15'(raddr);
        end else if (can_wr) begin
            h = m_q[0];
            if (int'(h.a) < FB_W * FB_H) begin
                e_en = 1'b1; e_we = 1'b1; e_addr = h.a; e_data = h.d;
            end
        end
        check_val("wr_ready", 32'(wr_ready), 32'(e_rdy));
        check_val("fifo_level", 32'(fifo_level), 32'(m_q.size()));
        check_val("pixel", 32'(pixel), 32'(m_pixel));
        check_val("oob_err", 32'(oob_err), 32'(m_oob));
        check_val("mem_en", 32'(mem_en), 32'(e_en));
        check_val("mem_we", 32'(mem_we), 32'(e_we));
        if (e_en) check_val("mem_addr", 32'(mem_addr), 32'(e_addr));
        if (e_we) check_val("mem_wdata", 32'(mem_wdata), 32'(e_data));
        if (reset_n) begin
            if (m_prev_disp)  m_pixel = m_rd;
            else if (p_tick)  m_pixel = 8'd0;
            if (disp) m_rd = ref_vram[e_addr];
            if (can_wr) begin
                h = m_q.pop_front();
                if (int'(h.a) >= FB_W * FB_H) m_oob = 1'b1;
                else                          ref_vram[h.a] = h.d;
            end
            if (wr_valid && e_rdy) begin
                h.a = wr_addr; h.d = wr_data;
                m_q.push_back(h);
            end
            m_prev_disp = disp;
            m_ready_en  = 1'b1;
        end
        @(posedge clk);
        #1;
        if (!pt_hold) p_tick = ~p_tick;
    endtask

    task automatic align_tick0();
        if (p_tick) cycle();
    endtask

    task automatic push_one(input logic [14:0] a, input logic [7:0] d);
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        cycle();
        wr_valid = 1'b0;
    endtask

    task automatic blank_run(input int n);
        video_on = 1'b0; y = 10'd480;
        repeat (n) cycle();
    endtask

    initial begin
        logic acc;
        for (int i = 0; i < 32768; i++) begin
            vram[i] = 8'd0; ref_vram[i] = 8'd0;
        end
        n_vec = 0; n_err = 0; pt_hold = 1'b0;
        m_q.delete(); m_pixel = 0; m_rd = 0; m_prev_disp = 0; m_oob = 0; m_ready_en = 0;
        mem_rdata = 8'd0;
        reset_n = 1'b1; p_tick = 1'b0; video_on = 1'b0; x = '0; y = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        #1 reset_n = 1'b0;
        repeat (4) cycle();
        reset_n = 1'b1;
        cycle();
        check_val("ready_after_reset", 32'(wr_ready), 32'd1);

        // Scanout of one framebuffer pixel over four screen columns.
        vram[0] = 8'hA5; ref_vram[0] = 8'hA5;
        align_tick0();
        video_on = 1'b1; y = 10'd0;
        for (int xi = 0; xi < 4; xi++) begin
            x = 10'(xi);
            cycle();
            cycle();
            check_val("scan_pixel", 32'(pixel), 32'hA5);
        end
        video_on = 1'b0; x = 10'd640;
        cycle();

        // Write during active video lands in a p_tick=1 slot.
        align_tick0();
        video_on = 1'b1; y = 10'd8; x = 10'd20;
        push_one(15'd5, 8'h3C);
        repeat (6) cycle();
        blank_run(4);
        check_val("arb_write", 32'(vram[5]), 32'h3C);

        // Fill the queue while every cycle is a read slot.
        pt_hold = 1'b1; p_tick = 1'b0; video_on = 1'b1; y = 10'd0; x = 10'd0;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1; wr_addr = 15'(100 + i); wr_data = 8'(8'h10 + i);
            cycle();
        end
        cycle();
        check_val("full_level", 32'(fifo_level), 32'd4);
        check_val("full_ready", 32'(wr_ready), 32'd0);
        pt_hold = 1'b0; video_on = 1'b0; y = 10'd480;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) begin
            acc = wr_ready;
            cycle();
        end
        check_val("beat5_accept", 32'(acc), 32'd1);
        wr_valid = 1'b0;
        blank_run(10);
        for (int i = 0; i < 5; i++)
            check_val("drain_data", 32'(vram[100 + i]), 32'(8'h10 + i));

        // Out-of-range write is dropped and sets the sticky flag.
        push_one(15'd19200, 8'hFF);
        blank_run(4);
        check_val("oob_flag", 32'(oob_err), 32'd1);
        push_one(15'd9, 8'h77);
        blank_run(4);
        check_val("oob_sticky", 32'(oob_err), 32'd1);

        // A write queued during active lines is written once blank is reached.
        align_tick0();
        video_on = 1'b1; y = 10'd100; x = 10'd40;
        push_one(15'd7, 8'h5A);
        repeat (10) cycle();
        blank_run(4);
        check_val("vblank_write", 32'(vram[7]), 32'h5A);

        // Reset with three queued writes flushes them.
        pt_hold = 1'b1; p_tick = 1'b0; video_on = 1'b1; y = 10'd0;
        for (int i = 0; i < 3; i++) push_one(15'(200 + i), 8'hE0);
        check_val("pre_reset_level", 32'(fifo_level), 32'd3);
        reset_n = 1'b0;
        repeat (2) cycle();
        check_val("rst_level", 32'(fifo_level), 32'd0);
        check_val("rst_pixel", 32'(pixel), 32'd0);
        check_val("rst_mem_en", 32'(mem_en), 32'd0);
        check_val("rst_oob", 32'(oob_err), 32'd0);
        reset_n = 1'b1; pt_hold = 1'b0;
        cycle();
        check_val("rst_ready", 32'(wr_ready), 32'd1);
        blank_run(6);
        check_val("flushed", 32'(vram[200]), 32'd0);

        // Randomized traffic, with one reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            if (!p_tick) begin
                x = 10'($urandom_range(0, 799));
                y = ($urandom_range(0, 9) < 3) ? 10'($urandom_range(480, 524)) : 10'($urandom_range(0, 479));
                video_on = (x < 10'd640) && (y < 10'd480);
            end
            wr_valid = $urandom_range(0, 1) == 1;
            wr_addr  = ($urandom_range(0, 15) == 0) ? 15'($urandom_range(19200, 32767))
                                                    : 15'($urandom_range(0, 19199));
            wr_data  = 8'($urandom);
            reset_n  = !(i >= 1500 && i < 1502);
            cycle();
        end
        wr_valid = 1'b0;
        blank_run(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
